// File: rtl/chad_coproc.sv
// chad_coproc: multi-cycle arithmetic coprocessor for the CPU's cop port.
// Unsigned/signed shift-add multiply, restoring divide, barrel shifts, and a
// read-select register that puts lo, hi or status on y.
// Build option: define CHAD_COPROC_DIVIDE_EN to include the divider. Without it,
// UDIV completes in one cycle with hi = lo = all ones and nodiv set.
module chad_coproc #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [10:0]      sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_SETRD = 3'd0;
    localparam logic [2:0] OP_UMUL  = 3'd1;
    localparam logic [2:0] OP_SMUL  = 3'd2;
    localparam logic [2:0] OP_UDIV  = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_SAR   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef CHAD_COPROC_DIVIDE_EN
        S_DIV  = 2'd2,
`endif
        S_FIX  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo;
    logic [1:0]       rsel;
    logic             dz, ovf, nodiv;

    // Iteration working registers: product/remainder high half, multiplier/quotient
    // low half, and the multiplicand or divisor.
    logic [WIDTH-1:0] work_hi, work_lo, operand;
    logic             smul, neg;

    logic [2:0] op;
    logic       last;
    logic       unused_sel;

    assign op         = sel[2:0];
    assign last       = (cnt == CW'(WIDTH - 1));
    assign busy       = (state != S_IDLE);
    assign unused_sel = ^sel[10:5];

    // One shift-add multiply step: conditionally add the multiplicand, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*WIDTH-1:0] fix_val;
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output first, so no latches form.
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], work_lo[WIDTH-1:1]};
        fix_val   = neg ? (~{work_hi, work_lo} + 1'b1) : {work_hi, work_lo};
    end

    // Magnitudes for the signed multiply; the most negative value maps to 2^(WIDTH-1).
    logic [WIDTH-1:0] a_mag, b_mag;
    always_comb begin
        a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
    end

`ifdef CHAD_COPROC_DIVIDE_EN
    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_take;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    always_comb begin
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        div_take  = ~div_diff[WIDTH];
        rem_nx    = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nx    = {work_lo[WIDTH-2:0], div_take};
    end
`endif

    // Single-cycle shifter, saturating at WIDTH positions.
    logic [4:0]       amt;
    logic             sat;
    logic [WIDTH-1:0] shift_res;
    always_comb begin
        amt = b[4:0];
        sat = ({1'b0, amt} >= 6'(WIDTH));
        case (op)
            OP_SHL:  shift_res = sat ? '0 : (a << amt);
            OP_SHR:  shift_res = sat ? '0 : (a >> amt);
            OP_SAR:  shift_res = sat ? {WIDTH{a[WIDTH-1]}} : ($signed(a) >>> amt);
            default: shift_res = '0;
        endcase
    end

    // Read-select mux onto the CPU result bus.
    always_comb begin
        case (rsel)
            2'd0:    y = lo;
            2'd1:    y = hi;
            2'd2:    y = {{(WIDTH-4){1'b0}}, busy, nodiv, ovf, dz};
            default: y = '0;
        endcase
    end

    // Control FSM and result registers; hi/lo only change when an operation completes.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking '<=' so every register sees pre-edge values.
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            rsel    <= 2'd0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
            nodiv   <= 1'b0;
            work_hi <= '0;
            work_lo <= '0;
            operand <= '0;
            smul    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (op != OP_SETRD && op != 3'd7) begin
                            rsel  <= 2'd0;
                            dz    <= 1'b0;
                            ovf   <= 1'b0;
                            nodiv <= 1'b0;
                        end
                        case (op)
                            OP_SETRD: rsel <= sel[4:3];
                            OP_UMUL, OP_SMUL: begin
                                smul    <= (op == OP_SMUL);
                                neg     <= (op == OP_SMUL) && (a[WIDTH-1] ^ b[WIDTH-1]);
                                operand <= (op == OP_SMUL) ? a_mag : a;
                                work_lo <= (op == OP_SMUL) ? b_mag : b;
                                work_hi <= '0;
                                cnt     <= '0;
                                state   <= S_MUL;
                            end
                            OP_UDIV: begin
`ifdef CHAD_COPROC_DIVIDE_EN
                                if (c == '0) begin
                                    lo <= '1;
                                    hi <= b;
                                    dz <= 1'b1;
                                end else if (a >= c) begin
                                    lo  <= '1;
                                    hi  <= '1;
                                    ovf <= 1'b1;
                                end else begin
                                    work_hi <= a;
                                    work_lo <= b;
                                    operand <= c;
                                    cnt     <= '0;
                                    state   <= S_DIV;
                                end
`else
                                lo    <= '1;
                                hi    <= '1;
                                nodiv <= 1'b1;
`endif
                            end
                            OP_SHL, OP_SHR, OP_SAR: begin
                                lo <= shift_res;
                                hi <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    work_hi <= mul_hi_nx;
                    work_lo <= mul_lo_nx;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        cnt <= '0;
                        if (smul) begin
                            state <= S_FIX;
                        end else begin
                            hi    <= mul_hi_nx;
                            lo    <= mul_lo_nx;
                            state <= S_IDLE;
                        end
                    end
                end
`ifdef CHAD_COPROC_DIVIDE_EN
                S_DIV: begin
                    work_hi <= rem_nx;
                    work_lo <= quo_nx;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        cnt   <= '0;
                        hi    <= rem_nx;
                        lo    <= quo_nx;
                        state <= S_IDLE;
                    end
                end
`endif
                S_FIX: begin
                    {hi, lo} <= fix_val;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chad_coproc.sv
// tb_chad_coproc: directed bench for chad_coproc at WIDTH=18.
// Divide checks follow CHAD_COPROC_DIVIDE_EN so the bench matches either build.
module tb_chad_coproc;

    localparam int WIDTH = 18;

    localparam logic [2:0] OP_SETRD = 3'd0;
    localparam logic [2:0] OP_UMUL  = 3'd1;
    localparam logic [2:0] OP_SMUL  = 3'd2;
    localparam logic [2:0] OP_UDIV  = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_SAR   = 3'd6;

    logic             clk = 1'b0;
    logic             reset;
    logic             go;
    logic [10:0]      sel;
    logic [WIDTH-1:0] a, b, c;
    logic [WIDTH-1:0] y;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chad_coproc #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .go   (go),
        .sel  (sel),
        .a    (a),
        .b    (b),
        .c    (c),
        .y    (y),
        .busy (busy)
    );

    // Present one command for a single cycle; returns on the falling edge after the go edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] rs,
                         input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic [WIDTH-1:0] tc);
        @(negedge clk);
        go  = 1'b1;
        sel = {6'h2A, rs, op};
        a   = ta;
        b   = tb;
        c   = tc;
        @(negedge clk);
        go  = 1'b0;
        sel = 11'h7FF;
        a   = '1;
        b   = '1;
        c   = '1;
    endtask

    task automatic read_sel(input logic [1:0] rs);
        issue(OP_SETRD, rs, '0, '0, '0);
    endtask

    // Count falling edges with busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; go = 1'b0; sel = '0; a = '0; b = '0; c = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (y !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_state: y=%h busy=%b, want y=0 busy=0", y, busy);
        end
        read_sel(2'd2);
        checks++;
        if (y !== '0) begin errors++; $display("FAIL reset_status: got %h want 00000", y); end
    endtask

    task automatic test_umul;
        int n;
        issue(OP_UMUL, 2'd3, 18'h3FFFF, 18'h3FFFF, 18'h00000);
        wait_idle(n);
        checks++;
        if (n !== 18) begin errors++; $display("FAIL umul_busy: got %0d cycles want 18", n); end
        checks++;
        if (y !== 18'h00001) begin errors++; $display("FAIL umul_lo: got %h want 00001", y); end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h3FFFE) begin errors++; $display("FAIL umul_hi: got %h want 3fffe", y); end
        read_sel(2'd2);
        checks++;
        if (y !== 18'h00000) begin errors++; $display("FAIL umul_status: got %h want 00000", y); end
    endtask

    task automatic test_smul;
        int n;
        issue(OP_SMUL, 2'd0, 18'h3FFFD, 18'h00005, 18'h00000);
        wait_idle(n);
        checks++;
        if (n !== 19) begin errors++; $display("FAIL smul_busy: got %0d cycles want 19", n); end
        checks++;
        if (y !== 18'h3FFF1) begin errors++; $display("FAIL smul_lo: got %h want 3fff1", y); end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h3FFFF) begin errors++; $display("FAIL smul_hi: got %h want 3ffff", y); end
        // -4 * -6 = 24: both negative, positive product
        issue(OP_SMUL, 2'd0, 18'h3FFFC, 18'h3FFFA, 18'h00000);
        wait_idle(n);
        checks++;
        if (y !== 18'h00018) begin errors++; $display("FAIL smul_negneg_lo: got %h want 00018", y); end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h00000) begin errors++; $display("FAIL smul_negneg_hi: got %h want 00000", y); end
    endtask

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } shift_vec_t;

    task automatic test_shifts;
        shift_vec_t v[6];
        v[0] = '{OP_SHL, 18'h00001, 18'd17, 18'h20000};
        v[1] = '{OP_SAR, 18'h20000, 18'd20, 18'h3FFFF};
        v[2] = '{OP_SHR, 18'h3FFFF, 18'd4,  18'h03FFF};
        v[3] = '{OP_SHL, 18'h00001, 18'd18, 18'h00000};
        v[4] = '{OP_SHR, 18'h20000, 18'd31, 18'h00000};
        v[5] = '{OP_SAR, 18'h10000, 18'h3FFE1, 18'h08000};
        for (int i = 0; i < 6; i++) begin
            issue(v[i].op, 2'd3, v[i].a, v[i].b, 18'h00000);
            checks++;
            if (y !== v[i].exp || busy !== 1'b0) begin
                errors++;
                $display("FAIL shift_%0d: got %h busy=%b want %h busy=0", i, y, busy, v[i].exp);
            end
        end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h00000) begin errors++; $display("FAIL shift_hi: got %h want 00000", y); end
    endtask

    task automatic test_udiv;
        int n;
`ifdef CHAD_COPROC_DIVIDE_EN
        issue(OP_UDIV, 2'd0, 18'h00001, 18'h00000, 18'h00003);
        wait_idle(n);
        checks++;
        if (n !== 18) begin errors++; $display("FAIL udiv_busy: got %0d cycles want 18", n); end
        checks++;
        if (y !== 18'h15555) begin errors++; $display("FAIL udiv_quot: got %h want 15555", y); end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h00001) begin errors++; $display("FAIL udiv_rem: got %h want 00001", y); end
        issue(OP_UDIV, 2'd0, 18'h00005, 18'h00123, 18'h00000);
        checks++;
        if (y !== 18'h3FFFF || busy !== 1'b0) begin
            errors++; $display("FAIL udiv_dz_lo: got %h busy=%b want 3ffff busy=0", y, busy);
        end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h00123) begin errors++; $display("FAIL udiv_dz_hi: got %h want 00123", y); end
        read_sel(2'd2);
        checks++;
        if (y !== 18'h00001) begin errors++; $display("FAIL udiv_dz_status: got %h want 00001", y); end
        issue(OP_UDIV, 2'd0, 18'h00005, 18'h00000, 18'h00003);
        checks++;
        if (y !== 18'h3FFFF || busy !== 1'b0) begin
            errors++; $display("FAIL udiv_ovf_lo: got %h busy=%b want 3ffff busy=0", y, busy);
        end
        read_sel(2'd2);
        checks++;
        if (y !== 18'h00002) begin errors++; $display("FAIL udiv_ovf_status: got %h want 00002", y); end
`else
        issue(OP_UDIV, 2'd0, 18'h00001, 18'h00000, 18'h00003);
        wait_idle(n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL nodiv_busy: got %0d cycles want 0", n); end
        checks++;
        if (y !== 18'h3FFFF) begin errors++; $display("FAIL nodiv_lo: got %h want 3ffff", y); end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h3FFFF) begin errors++; $display("FAIL nodiv_hi: got %h want 3ffff", y); end
        read_sel(2'd2);
        checks++;
        if (y !== 18'h00004) begin errors++; $display("FAIL nodiv_status: got %h want 00004", y); end
`endif
    endtask

    task automatic test_go_while_busy;
        int n;
        issue(OP_SHL, 2'd0, 18'h00001, 18'd4, 18'h00000);
        issue(OP_UMUL, 2'd0, 18'h00003, 18'h00005, 18'h00000);
        n = 0;
        while (busy && n < 200) begin
            if (n == 3) begin
                go = 1'b1; sel = {6'h00, 2'd1, OP_SHL}; a = 18'h00001; b = 18'h00000;
            end else begin
                go = 1'b0;
            end
            if (n == 6) begin
                checks++;
                if (y !== 18'h00010) begin errors++; $display("FAIL hold_while_busy: got %h want 00010", y); end
            end
            n++;
            @(negedge clk);
        end
        go = 1'b0;
        checks++;
        if (n !== 18) begin errors++; $display("FAIL go_busy_cycles: got %0d want 18", n); end
        checks++;
        if (y !== 18'h0000F) begin errors++; $display("FAIL go_busy_lo: got %h want 0000f", y); end
        read_sel(2'd1);
        checks++;
        if (y !== 18'h00000) begin errors++; $display("FAIL go_busy_hi: got %h want 00000", y); end
    endtask

    task automatic test_reset_mid;
        issue(OP_UMUL, 2'd0, 18'h3FFFF, 18'h3FFFF, 18'h00000);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || y !== '0) begin
            errors++; $display("FAIL reset_mid: busy=%b y=%h want busy=0 y=0", busy, y);
        end
        read_sel(2'd1);
        checks++;
        if (y !== '0) begin errors++; $display("FAIL reset_mid_hi: got %h want 00000", y); end
        // Reset and go in the same cycle: reset wins, command discarded.
        issue(OP_SHL, 2'd0, 18'h00001, 18'd1, 18'h00000);
        @(negedge clk);
        reset = 1'b1; go = 1'b1; sel = {6'h00, 2'd0, OP_UMUL}; a = 18'h00003; b = 18'h00005;
        @(negedge clk);
        reset = 1'b0; go = 1'b0;
        checks++;
        if (busy !== 1'b0 || y !== '0) begin
            errors++; $display("FAIL reset_go: busy=%b y=%h want busy=0 y=0", busy, y);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_go_later: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset;
        test_umul;
        test_smul;
        test_shifts;
        test_udiv;
        test_go_while_busy;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/chad_coproc.md
CHAD_COPROC -- requirements
Module: chad_coproc

Interface
REQ-001 SHALL have parameter WIDTH, default 18, datapath width; legal range 16 to 32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port go  input  1  command strobe, one cycle per command (CPU copgo).
REQ-005 SHALL have port sel  input  11  command select; sel[2:0] opcode, sel[4:3] read select, sel[10:5] ignored.
REQ-006 SHALL have ports a, b, c  input  WIDTH each  operands (CPU T, N, W), sampled only in the go cycle.
REQ-007 SHALL have port y  output  WIDTH  result to the CPU cop input.
REQ-008 SHALL have port busy  output  1  high while a multi-cycle op runs; the CPU drives hold from it.

Function
REQ-009 SHALL decode opcodes: 0 SETRD, 1 UMUL, 2 SMUL, 3 UDIV, 4 SHL, 5 SHR, 6 SAR, 7 NOP.
REQ-010 SHALL ignore go while busy=1: no state change and no error.
REQ-011 SHALL run SETRD in one cycle, loading register rsel from sel[4:3]; results and flags unchanged.
REQ-012 SHALL have y = lo when rsel=0, hi when rsel=1, status when rsel=2, zero when rsel=3.
REQ-013 SHALL form status from bit 0 dz, bit 1 ovf, bit 2 nodiv and bit 3 busy, with all other bits zero.
REQ-014 SHALL, for every opcode 1-6, clear rsel, dz, ovf and nodiv in the go cycle.
REQ-015 SHALL run UMUL on a*b unsigned, radix-2 shift-add, to give a 2*WIDTH product {hi,lo}.
REQ-016 SHALL have UMUL busy for exactly WIDTH cycles starting the cycle after go, with the result valid when busy falls.
REQ-017 SHALL run SMUL as a two's-complement a*b, using magnitude multiply plus one FIX cycle for sign correction, with busy high for WIDTH+1 cycles.
REQ-018 SHALL run UDIV as restoring division of dividend {a,b} (a high) by divisor c, giving lo=quotient and hi=remainder, with busy high for WIDTH cycles.
REQ-019 SHALL, for UDIV with c=0, give a 1-cycle result: lo all ones, hi=b, dz=1, busy never asserted.
REQ-020 SHALL, for UDIV with a>=c and c!=0 (quotient overflow), give a 1-cycle result: lo and hi all ones, ovf=1.
REQ-021 SHALL run SHL, SHR and SAR in one cycle on a, shifted by b[4:0], saturating to WIDTH: lo=result, hi=0.
REQ-022 SHALL, for shift amount >= WIDTH, give zero for SHL and SHR, and fill SAR with a[WIDTH-1].
REQ-023 SHALL treat NOP as a no-op.
REQ-024 SHALL implement the state machine IDLE -> MUL | DIV on go with opcodes 1, 2 or 3 (except the early-exit cases), as follows:
  - MUL and DIV hold an iteration counter 0..WIDTH-1;
  - on the last iteration, MUL -> FIX (SMUL) or IDLE, DIV -> IDLE;
  - FIX -> IDLE;
  - busy = (state != IDLE).
REQ-025 SHALL have registers hi and lo hold their previous result while busy, updating atomically on the final cycle only.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, including mid-operation, set state IDLE, busy 0, counter 0, hi 0, lo 0, rsel 0, dz 0, ovf 0 and nodiv 0, so that y=0.
REQ-027 SHALL, when reset and go are high in the same cycle, let reset win and discard the command.

Configuration
REQ-028 SHALL gate the divider with macro CHAD_COPROC_DIVIDE_EN; when it is defined, UDIV behaves per REQ-018 to REQ-020.
REQ-029 SHALL, when CHAD_COPROC_DIVIDE_EN is undefined, omit the divide datapath and DIV state; UDIV then completes in 1 cycle with hi and lo all ones, nodiv=1, busy never asserted.

Verification (WIDTH=18)
REQ-030 SHALL cover UMUL: a=0x3FFFF, b=0x3FFFF -> busy 18 cycles, then lo=0x00001, and after SETRD rsel=1, y=hi=0x3FFFE.
REQ-031 SHALL cover SMUL: a=0x3FFFD (-3), b=0x00005 -> busy 19 cycles, then lo=0x3FFF1, hi=0x3FFFF.
REQ-032 SHALL cover UDIV: a=0x00001, b=0x00000, c=0x00003 -> busy 18 cycles, lo=0x15555, hi=0x00001. Also c=0 -> lo=0x3FFFF, dz=1, busy stays 0.
REQ-033 SHALL cover shifts: SHL a=0x00001, b=17 -> lo=0x20000 next cycle. SAR a=0x20000, b=20 -> lo=0x3FFFF.
REQ-034 SHALL cover reset and go-while-busy: reset raised 5 cycles into UMUL -> next cycle busy=0, y=0. A go during busy leaves hi, lo and the cycle count unchanged.
REQ-035 SHALL cover the config without CHAD_COPROC_DIVIDE_EN: UDIV -> 1 cycle, hi=lo=0x3FFFF, status (rsel=2) = 0x00004.
